// File: rtl/present_decrypt.sv
// ---------------------------------------------------------------------------
// present_decrypt
//   Iterative PRESENT-80 block-decryption core, one inverse round per clock.
//   A start request latches ciphertext and user key. The forward key schedule
//   then runs for 31 cycles to reach the final round key K32. One whitening
//   cycle removes K32, and 31 inverse rounds follow (inverse pLayer, inverse
//   sBoxLayer, round key) while the key schedule is unwound back to K1.
//
// Ports
//   clk    in   1   system clock, rising edge
//   rst    in   1   asynchronous active-high reset
//   start  in   1   operation request, sampled only while idle
//   key    in  80   user key (bit 79 = MSB), sampled with start
//   idat   in  64   ciphertext, sampled with start
//   odat   out 64   plaintext, valid while done=1, held until next start
//   busy   out  1   high while an operation is in flight
//   done   out  1   high once the result is written, until the next start
// ---------------------------------------------------------------------------
module present_decrypt #(
    parameter int ROUNDS = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [79:0] key,
    input  logic [63:0] idat,
    output logic [63:0] odat,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] LAST = 5'(ROUNDS);

    typedef enum logic [1:0] {IDLE, KEYEXP, WHITEN, ROUND} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q,   cnt_d;
    logic [79:0] kreg_q,  kreg_d;
    logic [63:0] st_q,    st_d;
    logic [63:0] odat_q,  odat_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
            4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
            4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
            4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
        endcase
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        case (x)
            4'h0: sbox_inv = 4'h5;  4'h1: sbox_inv = 4'hE;  4'h2: sbox_inv = 4'hF;  4'h3: sbox_inv = 4'h8;
            4'h4: sbox_inv = 4'hC;  4'h5: sbox_inv = 4'h1;  4'h6: sbox_inv = 4'h2;  4'h7: sbox_inv = 4'hD;
            4'h8: sbox_inv = 4'hB;  4'h9: sbox_inv = 4'h4;  4'hA: sbox_inv = 4'h6;  4'hB: sbox_inv = 4'h3;
            4'hC: sbox_inv = 4'h0;  4'hD: sbox_inv = 4'h7;  4'hE: sbox_inv = 4'h9;  default: sbox_inv = 4'hA;
        endcase
    endfunction

    // Forward key update: rotate left 61, S on the top nibble, counter into [19:15].
    function automatic logic [79:0] key_fwd(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] r;
        r          = {k[18:0], k[79:19]};
        r[79:76]   = sbox(r[79:76]);
        r[19:15]   = r[19:15] ^ rc;
        return r;
    endfunction

    // Exact inverse of key_fwd: steps undone in reverse order (rotate right 61).
    function automatic logic [79:0] key_inv(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] r;
        r          = k;
        r[19:15]   = r[19:15] ^ rc;
        r[79:76]   = sbox_inv(r[79:76]);
        return {r[60:0], r[79:61]};
    endfunction

    // Inverse round datapath: P^-1 is pure wiring, then sixteen S^-1 lookups.
    logic [63:0] pinv_w;
    logic [63:0] sinv_w;
    logic [79:0] kinv_w;

    for (genvar gi = 0; gi < 64; gi++) begin : g_pinv
        assign pinv_w[gi] = st_q[(gi == 63) ? 63 : ((16 * gi) % 63)];
    end

    for (genvar gn = 0; gn < 16; gn++) begin : g_sinv
        assign sinv_w[4*gn +: 4] = sbox_inv(pinv_w[4*gn +: 4]);
    end

    // Unwinding with the current counter yields K_cnt, the key this round needs.
    assign kinv_w = key_inv(kreg_q, cnt_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kreg_d  = kreg_q;
        st_d    = st_q;
        odat_d  = odat_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    st_d    = idat;
                    kreg_d  = key;
                    cnt_d   = 5'd1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = KEYEXP;
                end
            end
            KEYEXP: begin
                kreg_d = key_fwd(kreg_q, cnt_q);
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == LAST) begin
                    state_d = WHITEN;
                end
            end
            WHITEN: begin
                // kreg now holds K32; remove the final whitening key first.
                st_d    = st_q ^ kreg_q[79:16];
                cnt_d   = LAST;
                state_d = ROUND;
            end
            ROUND: begin
                kreg_d = kinv_w;
                st_d   = sinv_w ^ kinv_w[79:16];
                cnt_d  = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    // kinv_w is K1 here, so kreg ends back at the user key.
                    odat_d  = sinv_w ^ kinv_w[79:16];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            kreg_q  <= '0;
            st_q    <= '0;
            odat_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kreg_q  <= kreg_d;
            st_q    <= st_d;
            odat_q  <= odat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign odat = odat_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_present_decrypt.sv
// ---------------------------------------------------------------------------
// tb_present_decrypt
//   Directed bench for present_decrypt: table of published PRESENT-80 vectors
//   plus hand-written sequences for start-while-busy, mid-run reset and
//   back-to-back operation with start held high.
// ---------------------------------------------------------------------------
module tb_present_decrypt;

    logic        clk;
    logic        rst;
    logic        start;
    logic [79:0] key;
    logic [63:0] idat;
    logic [63:0] odat;
    logic        busy;
    logic        done;

    int tests;
    int fails;

    present_decrypt #(.ROUNDS(31)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .key   (key),
        .idat  (idat),
        .odat  (odat),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [79:0] k;
        logic [63:0] ct;
        logic [63:0] pt;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse start for one edge (edge 0), then count edges until done rises.
    task automatic run_op(input logic [79:0] k, input logic [63:0] ct,
                          output int lat, output int busy_hi);
        @(negedge clk);
        start = 1'b1; key = k; idat = ct;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        busy_hi = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (busy) busy_hi++;
        end
    endtask

    initial begin
        int lat, bh, e, ndone, last_rise;
        logic prev_done;
        logic [63:0] held;
        tests = 0;
        fails = 0;

        vecs[0] = '{k: 80'h0,                    ct: 64'h5579C1387B228445, pt: 64'h0000000000000000};
        vecs[1] = '{k: 80'hFFFFFFFFFFFFFFFFFFFF, ct: 64'hE72C46C0F5945049, pt: 64'h0000000000000000};
        vecs[2] = '{k: 80'h0,                    ct: 64'hA112FFC72F68417B, pt: 64'hFFFFFFFFFFFFFFFF};
        vecs[3] = '{k: 80'hFFFFFFFFFFFFFFFFFFFF, ct: 64'h3333DCD3213210D2, pt: 64'hFFFFFFFFFFFFFFFF};

        rst = 1'b1; start = 1'b0; key = '0; idat = '0;
        repeat (2) @(negedge clk);
        check("reset_odat", 80'(odat), 80'h0);
        check("reset_busy", 80'(busy), 80'h0);
        check("reset_done", 80'(done), 80'h0);
        rst = 1'b0;
        @(negedge clk);

        // Known-answer vectors.
        for (int i = 0; i < 4; i++) begin
            run_op(vecs[i].k, vecs[i].ct, lat, bh);
            check($sformatf("v%0d_latency", i), 80'(lat), 80'd63);
            check($sformatf("v%0d_odat", i), 80'(odat), 80'(vecs[i].pt));
            check($sformatf("v%0d_busy_cycles", i), 80'(bh), 80'd62);
            check($sformatf("v%0d_busy_end", i), 80'(busy), 80'h0);
        end

        // Result holds while idle with start low.
        repeat (5) @(negedge clk);
        check("hold_done", 80'(done), 80'h1);
        check("hold_odat", 80'(odat), 80'hFFFFFFFFFFFFFFFF);

        // Reset at edge 40 aborts; outputs clear without a clock edge.
        @(negedge clk);
        start = 1'b1; key = vecs[0].k; idat = vecs[0].ct;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("accept_done_low", 80'(done), 80'h0);
        check("accept_busy_high", 80'(busy), 80'h1);
        repeat (40) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_odat", 80'(odat), 80'h0);
        check("async_rst_busy", 80'(busy), 80'h0);
        check("async_rst_done", 80'(done), 80'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_op(vecs[1].k, vecs[1].ct, lat, bh);
        check("post_rst_latency", 80'(lat), 80'd63);
        check("post_rst_odat", 80'(odat), 80'(vecs[1].pt));

        // Start re-pulsed at edge 20 with other inputs is ignored.
        @(negedge clk);
        start = 1'b1; key = vecs[2].k; idat = vecs[2].ct;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            if (lat == 19) begin
                start = 1'b1; key = vecs[0].k; idat = vecs[0].ct;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start = 1'b0;
        check("repulse_latency", 80'(lat), 80'd63);
        check("repulse_odat", 80'(odat), 80'(vecs[2].pt));

        // Start held high: back-to-back runs, done high one cycle each time.
        @(negedge clk);
        start = 1'b1; key = vecs[0].k; idat = vecs[0].ct;
        @(posedge clk);
        @(negedge clk);
        e = 0; ndone = 0; last_rise = -1; prev_done = done;
        held = odat;
        check("held_first_done_low", 80'(done), 80'h0);
        check("held_odat_before", 80'(held), 80'hFFFFFFFFFFFFFFFF);
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            if (done) begin
                ndone++;
                check($sformatf("held_odat_e%0d", e), 80'(odat), 80'h0);
                if (!prev_done) begin
                    if (last_rise >= 0)
                        check($sformatf("held_period_e%0d", e), 80'(e - last_rise), 80'd64);
                    else
                        check("held_first_rise", 80'(e), 80'd63);
                    last_rise = e;
                end
            end
            prev_done = done;
        end
        start = 1'b0;
        // Rises at edges 63, 127, 191, each lasting exactly one cycle.
        check("held_done_cycles", 80'(ndone), 80'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
